// File: rtl/memShare_config_pkg.sv
// Shared-memory configuration constants reused by the message-pass blocks.
package memShare_config_pkg;
    localparam int DRC_INC_BIT  = 1;  // take external next-offset operand
    localparam int DRC_HOLD_BIT = 0;  // keep current offset
endpackage

// File: rtl/msgPass_config_pkg.sv
// Message-pass defaults and the address generator state encoding.
package msgPass_config_pkg;
    localparam int MP_CH_NUM     = 4;
    localparam int MP_ADDR_WIDTH = 10;
    localparam int MP_INC_WIDTH  = 8;
    localparam int MP_DRC_NUM    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mp_state_e;
endpackage

// File: rtl/msgpass_offset_cnt.sv
// Shared offset sequence, transfer counter and latched burst length.
module msgpass_offset_cnt
    import memShare_config_pkg::*;
#(
    parameter int INC_WIDTH = 8,
    parameter int DRC_NUM   = 2
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [INC_WIDTH-1:0] len_i,
    input  logic                 xfer_i,
    input  logic [DRC_NUM-1:0]   is_drc_i,
    input  logic [INC_WIDTH-1:0] drc_inc_i,
    output logic [INC_WIDTH-1:0] offset_d_o,
    output logic                 last_o
);
    logic [INC_WIDTH-1:0] offset_q, cnt_q, len_q;

    // Next offset is exported so the parent can register addresses without an extra cycle.
    always_comb begin
        offset_d_o = offset_q;
        if (load_i)
            offset_d_o = '0;
        else if (xfer_i) begin
            if (is_drc_i[DRC_INC_BIT])
                offset_d_o = drc_inc_i;
            else if (!is_drc_i[DRC_HOLD_BIT])
                offset_d_o = offset_q + INC_WIDTH'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            offset_q <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
        end else begin
            offset_q <= offset_d_o;
            if (load_i) begin
                cnt_q <= '0;
                len_q <= len_i;
            end else if (xfer_i)
                cnt_q <= cnt_q + INC_WIDTH'(1);
        end
    end

    assign last_o = (cnt_q == len_q - INC_WIDTH'(1));
endmodule

// File: rtl/msgpass_mch_addr_gen.sv
// Multi-channel read address generator: per-channel base plus one shared offset sequence.
module msgpass_mch_addr_gen
    import msgPass_config_pkg::*;
#(
    parameter int CH_NUM     = MP_CH_NUM,
    parameter int ADDR_WIDTH = MP_ADDR_WIDTH,
    parameter int INC_WIDTH  = MP_INC_WIDTH,
    parameter int DRC_NUM    = MP_DRC_NUM
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [INC_WIDTH-1:0]         len_i,
    input  logic [CH_NUM-1:0]            base_wr_en_i,
    input  logic [ADDR_WIDTH-1:0]        base_wr_data_i,
    input  logic [DRC_NUM-1:0]           is_drc_i,
    input  logic [INC_WIDTH-1:0]         drc_inc_i,
    input  logic                         addr_ready_i,
    output logic [CH_NUM*ADDR_WIDTH-1:0] addr_o,
    output logic                         addr_valid_o,
    output logic                         busy_o,
    output logic                         done_o
);
    if (ADDR_WIDTH < INC_WIDTH) begin : g_width_chk
        $error("msgpass_mch_addr_gen: ADDR_WIDTH must be >= INC_WIDTH");
    end

    mp_state_e                             state_q;
    logic [CH_NUM-1:0][ADDR_WIDTH-1:0]     base_q, base_d, addr_q, addr_sum;
    logic [INC_WIDTH-1:0]                  off_nxt;
    logic                                  valid_q, busy_q, done_q;
    logic                                  start_ok, xfer, last;

    assign start_ok = (state_q == ST_IDLE) && start_i && (len_i != '0);
    assign xfer     = (state_q == ST_RUN) && addr_ready_i;

    msgpass_offset_cnt #(
        .INC_WIDTH (INC_WIDTH),
        .DRC_NUM   (DRC_NUM)
    ) u_offset_cnt (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .load_i     (start_ok),
        .len_i      (len_i),
        .xfer_i     (xfer),
        .is_drc_i   (is_drc_i),
        .drc_inc_i  (drc_inc_i),
        .offset_d_o (off_nxt),
        .last_o     (last)
    );

    // Base writes bypass into the sum so a same-cycle start sees the new base.
    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        assign base_d[c]   = ((state_q == ST_IDLE) && base_wr_en_i[c]) ? base_wr_data_i : base_q[c];
        assign addr_sum[c] = base_d[c] + ADDR_WIDTH'(off_nxt);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            base_q <= base_d;
            case (state_q)
                ST_IDLE: if (start_ok) begin
                    state_q <= ST_RUN;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b1;
                    addr_q  <= addr_sum;
                end
                ST_RUN: if (xfer) begin
                    if (last) begin
                        state_q <= ST_DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        addr_q  <= '0;
                    end else
                        addr_q <= addr_sum;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign addr_o       = addr_q;
    assign addr_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
endmodule

// File: tb/tb_msgpass_mch_addr_gen.sv
// Randomized bench for msgpass_mch_addr_gen against a transaction-level address model.
module tb_msgpass_mch_addr_gen;
    localparam int CH = 4, AW = 10, IW = 8, DN = 2;

    logic              sys_clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic [IW-1:0]     len_i;
    logic [CH-1:0]     base_wr_en_i;
    logic [AW-1:0]     base_wr_data_i;
    logic [DN-1:0]     is_drc_i;
    logic [IW-1:0]     drc_inc_i;
    logic              addr_ready_i;
    logic [CH*AW-1:0]  addr_o;
    logic              addr_valid_o, busy_o, done_o;

    int vec = 0, err = 0;
    int mbase [CH];

    msgpass_mch_addr_gen #(.CH_NUM(CH), .ADDR_WIDTH(AW), .INC_WIDTH(IW), .DRC_NUM(DN)) dut (
        .sys_clk(sys_clk), .rst(rst), .start_i(start_i), .len_i(len_i),
        .base_wr_en_i(base_wr_en_i), .base_wr_data_i(base_wr_data_i),
        .is_drc_i(is_drc_i), .drc_inc_i(drc_inc_i), .addr_ready_i(addr_ready_i),
        .addr_o(addr_o), .addr_valid_o(addr_valid_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic cyc();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic write_base(input logic [CH-1:0] m, input int dat);
        base_wr_en_i = m; base_wr_data_i = AW'(dat);
        for (int c = 0; c < CH; c++) if (m[c]) mbase[c] = dat % (1 << AW);
        cyc();
        base_wr_en_i = '0;
    endtask

    task automatic do_start(input int len, input logic [CH-1:0] m, input int dat);
        start_i = 1'b1; len_i = IW'(len); base_wr_en_i = m; base_wr_data_i = AW'(dat);
        for (int c = 0; c < CH; c++) if (m[c]) mbase[c] = dat % (1 << AW);
        cyc();
        start_i = 1'b0; base_wr_en_i = '0;
    endtask

    // rdy_mode: 0 always ready, 1 random, 2 stalled for the first two valid cycles
    task automatic burst(input int len, input int rdy_mode, input bit drc_rnd,
                         input logic [1:0] drc0, input int inc0, input bit noise);
        int off = 0, cnt = 0, n = 0, inc, exp_a;
        logic [1:0] d;
        bit r;
        while (cnt < len && n < 40 * len + 40) begin
            vec++;
            if (addr_valid_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0) begin
                err++;
                $display("FAIL run_flags xfer%0d: valid=%b busy=%b done=%b want 1 1 0", cnt, addr_valid_o, busy_o, done_o);
            end
            for (int c = 0; c < CH; c++) begin
                exp_a = (mbase[c] + off) % (1 << AW);
                vec++;
                if (addr_o[c*AW +: AW] !== AW'(exp_a)) begin
                    err++;
                    $display("FAIL addr ch%0d xfer%0d: got %h want %h", c, cnt, addr_o[c*AW +: AW], exp_a);
                end
            end
            case (rdy_mode)
                0: r = 1'b1;
                1: r = 1'($urandom_range(0, 1));
                default: r = (n >= 2);
            endcase
            if (drc_rnd) begin
                d = 2'($urandom_range(0, 3)); inc = $urandom_range(0, 255);
            end else if (cnt == 0) begin
                d = drc0; inc = inc0;
            end else begin
                d = 2'b00; inc = $urandom_range(0, 255);
            end
            addr_ready_i = r; is_drc_i = d; drc_inc_i = IW'(inc);
            if (noise) begin
                start_i = 1'($urandom_range(0, 1)); len_i = IW'($urandom);
                base_wr_en_i = CH'($urandom); base_wr_data_i = AW'($urandom);
            end
            cyc();
            if (r) begin
                cnt++;
                off = d[1] ? inc : (d[0] ? off : (off + 1) % (1 << IW));
            end
            n++;
        end
        addr_ready_i = 1'b0; start_i = 1'b0; base_wr_en_i = '0; is_drc_i = '0;
        vec++;
        if (cnt < len) begin
            err++;
            $display("FAIL burst_timeout: got %0d transfers want %0d", cnt, len);
        end
        vec++;
        if (done_o !== 1'b1 || addr_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            err++;
            $display("FAIL done_pulse: done=%b valid=%b busy=%b want 1 0 1", done_o, addr_valid_o, busy_o);
        end
        cyc();
        vec++;
        if (done_o !== 1'b0 || addr_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            err++;
            $display("FAIL back_idle: done=%b valid=%b busy=%b want 0 0 0", done_o, addr_valid_o, busy_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 0; len_i = '0; base_wr_en_i = '0; base_wr_data_i = '0;
        is_drc_i = '0; drc_inc_i = '0; addr_ready_i = 0;
        for (int c = 0; c < CH; c++) mbase[c] = 0;
        cyc(); cyc();
        vec++;
        if (addr_o !== '0 || addr_valid_o !== 0 || busy_o !== 0 || done_o !== 0) begin
            err++;
            $display("FAIL reset_state: addr=%h v=%b b=%b d=%b want all 0", addr_o, addr_valid_o, busy_o, done_o);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        for (int c = 0; c < CH; c++) write_base(CH'(1 << c), c * 'h100);
        do_start(4, '0, 0);
        burst(4, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic test_back_pressure();
        do_start(3, '0, 0);
        burst(3, 2, 0, 2'b00, 0, 0);
    endtask

    task automatic test_drc();
        do_start(2, '0, 0); burst(2, 0, 0, 2'b10, 'h40, 0);
        do_start(2, '0, 0); burst(2, 0, 0, 2'b11, 'h40, 0);
        do_start(3, '0, 0); burst(3, 0, 0, 2'b01, 'h40, 0);
    endtask

    task automatic test_wrap();
        write_base(4'b0001, 'h3FE);
        do_start(4, '0, 0); burst(4, 0, 0, 2'b00, 0, 0);
        do_start(4, '0, 0); burst(4, 1, 0, 2'b10, 'hFE, 0);
        do_start(255, '0, 0); burst(255, 1, 1, 2'b00, 0, 0);
    endtask

    task automatic test_ignored();
        do_start(0, '0, 0);
        for (int i = 0; i < 3; i++) begin
            vec++;
            if (addr_valid_o !== 0 || busy_o !== 0 || done_o !== 0) begin
                err++;
                $display("FAIL len0_ignored cyc%0d: v=%b b=%b d=%b want 0 0 0", i, addr_valid_o, busy_o, done_o);
            end
            cyc();
        end
        do_start(5, '0, 0); burst(5, 1, 0, 2'b00, 0, 1);
    endtask

    task automatic test_same_cycle_write();
        do_start(3, 4'b0110, 'h2A5);
        burst(3, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic test_reset_mid();
        write_base(4'b1111, 'h155);
        do_start(8, '0, 0);
        addr_ready_i = 1'b1;
        cyc();
        vec++;
        if (addr_o[AW +: AW] !== AW'(mbase[1] + 1)) begin
            err++;
            $display("FAIL mid_second_addr: got %h want %h", addr_o[AW +: AW], mbase[1] + 1);
        end
        #1 rst = 1'b1;
        #1;
        vec++;
        if (addr_o !== '0 || addr_valid_o !== 0 || busy_o !== 0 || done_o !== 0) begin
            err++;
            $display("FAIL mid_reset_outputs: addr=%h v=%b b=%b d=%b want all 0", addr_o, addr_valid_o, busy_o, done_o);
        end
        addr_ready_i = 1'b0;
        for (int c = 0; c < CH; c++) mbase[c] = 0;
        cyc();
        rst = 1'b0;
        cyc();
        vec++;
        if (done_o !== 0 || busy_o !== 0) begin
            err++;
            $display("FAIL mid_no_done: done=%b busy=%b want 0 0", done_o, busy_o);
        end
        do_start(2, '0, 0); burst(2, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            write_base(CH'($urandom), $urandom_range(0, (1 << AW) - 1));
            do_start($urandom_range(1, 20), CH'($urandom), $urandom_range(0, (1 << AW) - 1));
            burst(0, 0, 0, 2'b00, 0, 0) ;
        end
    endtask

    task automatic test_random_bursts();
        int len;
        for (int i = 0; i < 8; i++) begin
            write_base(CH'($urandom), $urandom_range(0, (1 << AW) - 1));
            len = $urandom_range(1, 20);
            do_start(len, CH'($urandom), $urandom_range(0, (1 << AW) - 1));
            burst(len, 1, 1, 2'b00, 0, 1);
        end
    endtask

    initial begin
        @(negedge sys_clk);
        test_reset();
        test_basic();
        test_back_pressure();
        test_drc();
        test_wrap();
        test_ignored();
        test_same_cycle_write();
        test_reset_mid();
        test_random_bursts();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
